// File: rtl/ap_host_seq.sv
// Host-side job sequencer for the 3-column associative processor: loads A/B operands,
// kicks and supervises the AP compute phase, then streams column C back to the host.
module ap_host_seq #(
    parameter int WORD_SIZE  = 8,
    parameter int CELL_QUANT = 512,
    parameter int RD_LAT     = 2,
    parameter int TIMEOUT    = 1024,
    localparam int ADDR_W    = $clog2(CELL_QUANT)
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_W:0]      num_cells,
    input  logic [2:0]           cmd_in,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WORD_SIZE-1:0] s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WORD_SIZE-1:0] m_data,
    output logic                 ap_rst,
    output logic                 ap_mode,
    output logic [2:0]           ap_cmd,
    output logic [ADDR_W-1:0]    ap_addr,
    output logic [WORD_SIZE-1:0] ap_wdata,
    output logic [1:0]           ap_sel_col,
    output logic                 ap_sel_internal_col,
    output logic                 ap_write_en,
    output logic                 ap_read_en,
    input  logic [WORD_SIZE-1:0] ap_rdata,
    input  logic                 ap_state_irq
);
    localparam int TW  = $clog2(TIMEOUT);
    localparam int RCW = $clog2(RD_LAT + 1);
    localparam logic [ADDR_W:0] NMAX = (ADDR_W + 1)'(CELL_QUANT);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_KICK, S_COMPUTE, S_RD_ISSUE, S_RD_WAIT, S_RD_OUT
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W:0]        n_q, n_d;
    logic [2:0]             cmd_q, cmd_d;
    logic [ADDR_W:0]        beat_q, beat_d;
    logic [ADDR_W-1:0]      cell_q, cell_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [RCW-1:0]         rcnt_q, rcnt_d;
    logic                   s_ready_q, s_ready_d;
    logic                   m_valid_q, m_valid_d;
    logic [WORD_SIZE-1:0]   m_data_q, m_data_d;
    logic                   ap_rst_q, ap_rst_d;
    logic                   ap_mode_q, ap_mode_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
    logic [1:0]             sel_col_q, sel_col_d;
    logic                   write_en_q, write_en_d;
    logic                   read_en_q, read_en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic [ADDR_W:0] last_beat;
    logic            last_cell;

    // 2N-1 in ADDR_W+1 bits; wraps correctly to all-ones when N == CELL_QUANT.
    assign last_beat = {n_q[ADDR_W-1:0], 1'b0} - 1'b1;
    assign last_cell = ({1'b0, cell_q} == (n_q - 1'b1));

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        cmd_d      = cmd_q;
        beat_d     = beat_q;
        cell_d     = cell_q;
        tcnt_d     = tcnt_q;
        rcnt_d     = rcnt_q;
        s_ready_d  = s_ready_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        ap_mode_d  = ap_mode_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sel_col_d  = sel_col_q;
        ap_rst_d   = 1'b0;
        write_en_d = 1'b0;
        read_en_d  = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_cells != '0 && num_cells <= NMAX) begin
                        n_d       = num_cells;
                        cmd_d     = cmd_in;
                        beat_d    = '0;
                        cell_d    = '0;
                        s_ready_d = 1'b1;
                        state_d   = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (s_valid && s_ready_q) begin
                    write_en_d = 1'b1;
                    addr_d     = beat_q[ADDR_W:1];
                    sel_col_d  = {1'b0, beat_q[0]};
                    wdata_d    = s_data;
                    beat_d     = beat_q + 1'b1;
                    if (beat_q == last_beat) begin
                        s_ready_d = 1'b0;
                        ap_rst_d  = 1'b1;
                        state_d   = S_KICK;
                    end
                end
            end
            S_KICK: begin
                ap_mode_d = 1'b1;
                tcnt_d    = '0;
                state_d   = S_COMPUTE;
            end
            S_COMPUTE: begin
                tcnt_d = tcnt_q + 1'b1;
                if (ap_state_irq) begin
                    ap_mode_d = 1'b0;
                    cell_d    = '0;
                    read_en_d = 1'b1;
                    sel_col_d = 2'd2;
                    addr_d    = '0;
                    state_d   = S_RD_ISSUE;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    ap_mode_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_RD_ISSUE: begin
                rcnt_d  = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                rcnt_d = rcnt_q + 1'b1;
                if (rcnt_q == RCW'(RD_LAT - 1)) begin
                    m_data_d  = ap_rdata;
                    m_valid_d = 1'b1;
                    state_d   = S_RD_OUT;
                end
            end
            S_RD_OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    if (last_cell) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cell_d    = cell_q + 1'b1;
                        read_en_d = 1'b1;
                        sel_col_d = 2'd2;
                        addr_d    = cell_q + 1'b1;
                        state_d   = S_RD_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK100MHZ or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            cmd_q      <= '0;
            beat_q     <= '0;
            cell_q     <= '0;
            tcnt_q     <= '0;
            rcnt_q     <= '0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            ap_rst_q   <= 1'b1;
            ap_mode_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_col_q  <= '0;
            write_en_q <= 1'b0;
            read_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cmd_q      <= cmd_d;
            beat_q     <= beat_d;
            cell_q     <= cell_d;
            tcnt_q     <= tcnt_d;
            rcnt_q     <= rcnt_d;
            s_ready_q  <= s_ready_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            ap_rst_q   <= ap_rst_d;
            ap_mode_q  <= ap_mode_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            sel_col_q  <= sel_col_d;
            write_en_q <= write_en_d;
            read_en_q  <= read_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign busy                = busy_q;
    assign done                = done_q;
    assign err                 = err_q;
    assign s_ready             = s_ready_q;
    assign m_valid             = m_valid_q;
    assign m_data              = m_data_q;
    assign ap_rst              = ap_rst_q;
    assign ap_mode             = ap_mode_q;
    assign ap_cmd              = cmd_q;
    assign ap_addr             = addr_q;
    assign ap_wdata            = wdata_q;
    assign ap_sel_col          = sel_col_q;
    assign ap_sel_internal_col = 1'b0;
    assign ap_write_en         = write_en_q;
    assign ap_read_en          = read_en_q;
endmodule

// File: tb/tb_ap_host_seq.sv
// Directed bench for ap_host_seq with a behavioural AP model (C = A + B, delayed irq).
module tb_ap_host_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [9:0] num_cells;
    logic [2:0] cmd_in;
    logic       busy, done, err;
    logic       s_valid, s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       ap_rst, ap_mode;
    logic [2:0] ap_cmd;
    logic [8:0] ap_addr;
    logic [7:0] ap_wdata;
    logic [1:0] ap_sel_col;
    logic       ap_sel_internal_col, ap_write_en, ap_read_en;
    logic [7:0] ap_rdata;
    logic       ap_state_irq;

    int total = 0;
    int bad = 0;

    ap_host_seq dut (
        .CLK100MHZ(clk), .rst(rst), .start(start), .num_cells(num_cells), .cmd_in(cmd_in),
        .busy(busy), .done(done), .err(err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .ap_rst(ap_rst), .ap_mode(ap_mode), .ap_cmd(ap_cmd), .ap_addr(ap_addr),
        .ap_wdata(ap_wdata), .ap_sel_col(ap_sel_col), .ap_sel_internal_col(ap_sel_internal_col),
        .ap_write_en(ap_write_en), .ap_read_en(ap_read_en), .ap_rdata(ap_rdata),
        .ap_state_irq(ap_state_irq)
    );

    always #5 clk = ~clk;

    // AP model: columns A/B written by the DUT, C = A + B, irq after irq_delay ap_mode cycles.
    logic [7:0] mem_a [0:511];
    logic [7:0] mem_b [0:511];
    logic [7:0] rd_p1;
    logic       irq;
    int         irq_cnt;
    int         irq_delay = 20;
    assign ap_state_irq = irq;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq <= 1'b0; irq_cnt <= 0; rd_p1 <= 8'h00; ap_rdata <= 8'h00;
        end else begin
            if (ap_write_en && ap_sel_col == 2'd0) mem_a[ap_addr] <= ap_wdata;
            if (ap_write_en && ap_sel_col == 2'd1) mem_b[ap_addr] <= ap_wdata;
            if (ap_rst) begin
                irq <= 1'b0; irq_cnt <= 0;
            end else if (ap_mode && irq_delay > 0) begin
                irq_cnt <= irq_cnt + 1;
                if (irq_cnt + 1 == irq_delay) irq <= 1'b1;
            end
            if (ap_read_en) rd_p1 <= 8'(mem_a[ap_addr] + mem_b[ap_addr]);
            ap_rdata <= rd_p1;
        end
    end

    // m_ready driver: 0 = held low, 1 = always high, 2 = low 5 cycles per presented beat.
    int mr_mode = 0;
    int low_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (mr_mode == 1) m_ready = 1'b1;
        else if (mr_mode == 2) begin
            if (m_valid && !m_ready) begin
                if (low_cnt == 5) m_ready = 1'b1;
                else low_cnt++;
            end else begin
                m_ready = 1'b0; low_cnt = 0;
            end
        end else m_ready = 1'b0;
    end

    // Observation monitor, sampled on the falling edge.
    logic       clr = 1'b0;
    logic [18:0] wr_q[$];
    logic [8:0]  rd_addr_q[$];
    logic [7:0]  res_q[$];
    int rst_cyc, mode_cyc, done_cnt, err_cnt, overlap, strobe_compute, rdsel_bad, stab_bad, busy_seen;
    logic [2:0] mode_cmd;
    logic       hold_pend;
    logic [7:0] hold_data;

    always @(negedge clk) begin
        if (clr) begin
            wr_q.delete(); rd_addr_q.delete(); res_q.delete();
            rst_cyc = 0; mode_cyc = 0; done_cnt = 0; err_cnt = 0; overlap = 0;
            strobe_compute = 0; rdsel_bad = 0; stab_bad = 0; busy_seen = 0;
            mode_cmd = 3'd0; hold_pend = 1'b0; hold_data = 8'h00;
        end else if (rst) begin
            if (ap_write_en) wr_q.push_back({ap_addr, ap_sel_col, ap_wdata});
            if (ap_read_en) begin
                rd_addr_q.push_back(ap_addr);
                if (ap_sel_col != 2'd2) rdsel_bad++;
            end
            if (ap_write_en && ap_read_en) overlap++;
            if (ap_mode && (ap_write_en || ap_read_en)) strobe_compute++;
            if (ap_rst) rst_cyc++;
            if (ap_mode) begin mode_cyc++; mode_cmd = ap_cmd; end
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (busy) busy_seen++;
            if (m_valid && m_ready) res_q.push_back(m_data);
            if (hold_pend && !(m_valid && m_data == hold_data)) stab_bad++;
            hold_pend = m_valid && !m_ready;
            hold_data = m_data;
        end else hold_pend = 1'b0;
    end

    logic [7:0] stim [0:1023];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        clr = 1'b1; @(negedge clk); #1; clr = 1'b0; tick();
    endtask

    task automatic start_job(input logic [9:0] n, input logic [2:0] c);
        start = 1'b1; num_cells = n; cmd_in = c;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beats(input int n, input bit rnd, input int limit, output int sent);
        int cyc = 0;
        bit v, hs;
        sent = 0;
        while (sent < n && cyc < limit) begin
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_valid = v; s_data = stim[sent];
            @(negedge clk); hs = v && s_ready;
            tick();
            if (hs) sent++;
            cyc++;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        int c = 0;
        while (busy && c < limit) begin tick(); c++; end
        ok = !busy;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; num_cells = '0; cmd_in = '0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if ({ap_rst, ap_mode, busy, done, err, s_ready, m_valid, ap_write_en, ap_read_en} !== 9'b1_0000_0000) begin
            bad++; $display("FAIL reset_ctrl got=%b want=100000000", {ap_rst, ap_mode, busy, done, err, s_ready, m_valid, ap_write_en, ap_read_en}); end
        total++; if ({ap_addr, ap_wdata, ap_sel_col, ap_cmd, m_data} !== '0) begin
            bad++; $display("FAIL reset_data got addr=%0h wd=%0h sel=%0d cmd=%0d md=%0h want 0", ap_addr, ap_wdata, ap_sel_col, ap_cmd, m_data); end
        rst = 1'b1;
        tick();
        total++; if (ap_rst !== 1'b0) begin bad++; $display("FAIL ap_rst_release got=%b want=0", ap_rst); end
    endtask

    task automatic test_reset_mid_load();
        int sent; bit ok;
        clear_mon();
        stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim[3] = 8'h44;
        start_job(10'd2, 3'd1);
        send_beats(3, 1'b0, 20, sent);
        #2 rst = 1'b0;
        #1;
        total++; if ({ap_rst, busy, s_ready, ap_write_en} !== 4'b1000) begin
            bad++; $display("FAIL reset_mid_load got rst/busy/srdy/we=%b want=1000", {ap_rst, busy, s_ready, ap_write_en}); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        tick();
        total++; if (done_cnt !== 0 || err_cnt !== 0) begin
            bad++; $display("FAIL discard_job got done=%0d err=%0d want 0 0", done_cnt, err_cnt); end
        clear_mon();
        mr_mode = 1;
        stim[0] = 8'h40; stim[1] = 8'h03;
        start_job(10'd1, 3'd2);
        send_beats(2, 1'b0, 20, sent);
        wait_idle(200, ok);
        tick();
        total++; if (!ok) begin bad++; $display("FAIL post_reset_timeout got busy=%b want=0", busy); end
        total++; if (res_q.size() !== 1 || res_q[0] !== 8'h43) begin
            bad++; $display("FAIL post_reset_result got n=%0d d=%0h want n=1 d=43", res_q.size(), res_q.size() > 0 ? res_q[0] : 8'h00); end
        total++; if (done_cnt !== 1 || err_cnt !== 0) begin
            bad++; $display("FAIL post_reset_done got done=%0d err=%0d want 1 0", done_cnt, err_cnt); end
    endtask

    task automatic test_basic();
        int sent; bit ok;
        logic [18:0] exp_wr [0:3];
        exp_wr[0] = {9'd0, 2'd0, 8'h05}; exp_wr[1] = {9'd0, 2'd1, 8'h0A};
        exp_wr[2] = {9'd1, 2'd0, 8'h11}; exp_wr[3] = {9'd1, 2'd1, 8'h22};
        clear_mon();
        mr_mode = 1; irq_delay = 20;
        stim[0] = 8'h05; stim[1] = 8'h0A; stim[2] = 8'h11; stim[3] = 8'h22;
        start_job(10'd2, 3'd3);
        send_beats(4, 1'b0, 20, sent);
        wait_idle(300, ok);
        tick();
        total++; if (!ok || sent != 4) begin bad++; $display("FAIL basic_complete got ok=%0d sent=%0d want 1 4", ok, sent); end
        total++; if (wr_q.size() !== 4) begin bad++; $display("FAIL basic_wr_count got=%0d want=4", wr_q.size()); end
        for (int i = 0; i < 4; i++) begin
            total++; if (i >= wr_q.size() || wr_q[i] !== exp_wr[i]) begin
                bad++; $display("FAIL basic_wr%0d got=%h want=%h", i, i < wr_q.size() ? wr_q[i] : 19'h0, exp_wr[i]); end
        end
        total++; if (rst_cyc !== 1) begin bad++; $display("FAIL basic_ap_rst got=%0d cycles want=1", rst_cyc); end
        total++; if (mode_cyc == 0 || mode_cmd !== 3'd3) begin
            bad++; $display("FAIL basic_mode got mode_cyc=%0d cmd=%0d want >0 and 3", mode_cyc, mode_cmd); end
        total++; if (rd_addr_q.size() !== 2 || rd_addr_q[0] !== 9'd0 || rd_addr_q[1] !== 9'd1 || rdsel_bad != 0) begin
            bad++; $display("FAIL basic_reads got n=%0d selbad=%0d want 2 reads at 0,1 col2", rd_addr_q.size(), rdsel_bad); end
        total++; if (res_q.size() !== 2 || res_q[0] !== 8'h0F || res_q[1] !== 8'h33) begin
            bad++; $display("FAIL basic_results got n=%0d want 0F,33", res_q.size()); end
        total++; if (done_cnt !== 1 || err_cnt !== 0 || overlap != 0 || strobe_compute != 0) begin
            bad++; $display("FAIL basic_ctrl got done=%0d err=%0d ovl=%0d stc=%0d want 1 0 0 0", done_cnt, err_cnt, overlap, strobe_compute); end
    endtask

    task automatic test_illegal();
        logic [9:0] nlist [0:1];
        nlist[0] = 10'd0; nlist[1] = 10'd513;
        clear_mon();
        for (int i = 0; i < 2; i++) begin
            start_job(nlist[i], 3'd4);
            total++; if (err !== 1'b1 || busy !== 1'b0) begin
                bad++; $display("FAIL illegal_%0d got err=%b busy=%b want 1 0", nlist[i], err, busy); end
            tick();
            total++; if (err !== 1'b0) begin bad++; $display("FAIL illegal_pulse_%0d got err=%b want 0", nlist[i], err); end
        end
        total++; if (err_cnt !== 2 || busy_seen != 0 || wr_q.size() != 0 || rd_addr_q.size() != 0) begin
            bad++; $display("FAIL illegal_summary got err=%0d busy=%0d wr=%0d rd=%0d want 2 0 0 0", err_cnt, busy_seen, wr_q.size(), rd_addr_q.size()); end
    endtask

    task automatic test_timeout();
        int sent; bit ok;
        clear_mon();
        irq_delay = 0;
        stim[0] = 8'h01; stim[1] = 8'h02;
        start_job(10'd1, 3'd5);
        send_beats(2, 1'b0, 20, sent);
        wait_idle(1500, ok);
        tick();
        total++; if (!ok) begin bad++; $display("FAIL timeout_return got busy=%b want=0", busy); end
        total++; if (mode_cyc !== 1024 || ap_mode !== 1'b0) begin
            bad++; $display("FAIL timeout_mode got cycles=%0d mode=%b want 1024 0", mode_cyc, ap_mode); end
        total++; if (err_cnt !== 1 || done_cnt !== 0 || rd_addr_q.size() != 0) begin
            bad++; $display("FAIL timeout_ctrl got err=%0d done=%0d rd=%0d want 1 0 0", err_cnt, done_cnt, rd_addr_q.size()); end
    endtask

    task automatic test_full_random();
        int sent, wbad, rbad; bit ok;
        logic [18:0] ew;
        logic [7:0] er;
        clear_mon();
        irq_delay = 20; mr_mode = 2;
        for (int k = 0; k < 1024; k++) stim[k] = 8'($urandom_range(0, 255));
        start_job(10'd512, 3'd7);
        send_beats(1024, 1'b1, 5000, sent);
        wait_idle(20000, ok);
        tick();
        mr_mode = 0;
        total++; if (!ok || sent != 1024) begin bad++; $display("FAIL full_complete got ok=%0d sent=%0d want 1 1024", ok, sent); end
        wbad = 0;
        for (int k = 0; k < 1024; k++) begin
            ew = {9'(k >> 1), 2'(k & 1), stim[k]};
            if (k >= wr_q.size() || wr_q[k] !== ew) wbad++;
        end
        total++; if (wr_q.size() !== 1024 || wbad != 0) begin
            bad++; $display("FAIL full_writes got n=%0d wrong=%0d want 1024 0", wr_q.size(), wbad); end
        rbad = 0;
        for (int i = 0; i < 512; i++) begin
            er = 8'(stim[2*i] + stim[2*i+1]);
            if (i >= res_q.size() || res_q[i] !== er || i >= rd_addr_q.size() || rd_addr_q[i] !== 9'(i)) rbad++;
        end
        total++; if (res_q.size() !== 512 || rbad != 0) begin
            bad++; $display("FAIL full_results got n=%0d wrong=%0d want 512 0", res_q.size(), rbad); end
        total++; if (stab_bad != 0) begin bad++; $display("FAIL full_hold got unstable=%0d want=0", stab_bad); end
        total++; if (done_cnt !== 1 || overlap != 0 || strobe_compute != 0) begin
            bad++; $display("FAIL full_ctrl got done=%0d ovl=%0d stc=%0d want 1 0 0", done_cnt, overlap, strobe_compute); end
    endtask

    task automatic test_start_ignored();
        int sent, c; bit ok;
        clear_mon();
        irq_delay = 20; mr_mode = 0;
        stim[0] = 8'h21; stim[1] = 8'h12;
        start_job(10'd1, 3'd6);
        send_beats(2, 1'b0, 20, sent);
        repeat (5) tick();
        total++; if (ap_mode !== 1'b1) begin bad++; $display("FAIL ign_in_compute got mode=%b want=1", ap_mode); end
        start_job(10'd2, 3'd5);
        c = 0;
        while (!m_valid && c < 200) begin tick(); c++; end
        start_job(10'd2, 3'd5);
        repeat (3) tick();
        total++; if (m_valid !== 1'b1 || m_data !== 8'h33) begin
            bad++; $display("FAIL ign_rd_out got valid=%b data=%h want 1 33", m_valid, m_data); end
        mr_mode = 1;
        wait_idle(100, ok);
        repeat (5) tick();
        mr_mode = 0;
        total++; if (!ok || busy !== 1'b0 || ap_cmd !== 3'd6) begin
            bad++; $display("FAIL ign_idle got ok=%0d busy=%b cmd=%0d want 1 0 6", ok, busy, ap_cmd); end
        total++; if (done_cnt !== 1 || res_q.size() !== 1 || wr_q.size() !== 2 || err_cnt != 0) begin
            bad++; $display("FAIL ign_single got done=%0d res=%0d wr=%0d err=%0d want 1 1 2 0", done_cnt, res_q.size(), wr_q.size(), err_cnt); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_load();
        test_basic();
        test_illegal();
        test_timeout();
        test_full_random();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
